// File: rtl/dom_dep_mult_pipe.sv
// dom_dep_mult_pipe: two-stage 2-share DOM-dependent GF(2^2) normal-basis multiplier, LANES wide, valid/ready.
module dom_dep_mult_pipe #(
  parameter int LANES = 4,
  parameter int RAND_ON_STALL = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*LANES-1:0] ax,
  input  logic [2*LANES-1:0] bx,
  input  logic [2*LANES-1:0] ay,
  input  logic [2*LANES-1:0] by,
  input  logic [2*LANES-1:0] z0,
  input  logic [2*LANES-1:0] z1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*LANES-1:0] aq,
  output logic [2*LANES-1:0] bq
);
  localparam int W = 2 * LANES;
  if (RAND_ON_STALL != 0) begin : g_bad_param
    $error("RAND_ON_STALL must be 0");
  end
  function automatic logic [1:0] mul(input logic [1:0] a, input logic [1:0] b);
    logic e;
    e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
  endfunction
  logic         s1_valid, adv1, adv2, accept;
  logic [W-1:0] ax_r, bx_r, ya_r, yb_r, ta_r, tb_r;
  logic [W-1:0] ta_n, tb_n, y_m, qa_n, qb_n;
  assign adv2     = ~out_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  assign in_ready = adv1;
  assign accept   = in_valid & in_ready;
  // y is recombined only from the two registered blinded shares
  assign y_m = ya_r ^ yb_r;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign ta_n[2*i+:2] = mul(ax[2*i+:2], z0[2*i+:2]) ^ z1[2*i+:2];
    assign tb_n[2*i+:2] = mul(bx[2*i+:2], z0[2*i+:2]) ^ z1[2*i+:2];
    assign qa_n[2*i+:2] = mul(ax_r[2*i+:2], y_m[2*i+:2]) ^ ta_r[2*i+:2];
    assign qb_n[2*i+:2] = mul(bx_r[2*i+:2], y_m[2*i+:2]) ^ tb_r[2*i+:2];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      ax_r      <= '0;
      bx_r      <= '0;
      ya_r      <= '0;
      yb_r      <= '0;
      ta_r      <= '0;
      tb_r      <= '0;
      aq        <= '0;
      bq        <= '0;
    end else begin
      if (adv1) s1_valid <= accept;
      if (accept) begin
        ax_r <= ax;
        bx_r <= bx;
        ya_r <= ay ^ z0;
        yb_r <= by;
        ta_r <= ta_n;
        tb_r <= tb_n;
      end
      if (adv2) out_valid <= s1_valid;
      if (adv2 && s1_valid) begin
        aq <= qa_n;
        bq <= qb_n;
      end
    end
  end
endmodule

// File: tb/tb_dom_dep_mult_pipe.sv
// tb_dom_dep_mult_pipe: directed + randomized checks of dom_dep_mult_pipe against a log-table GF(4) model and a result queue.
module tb_dom_dep_mult_pipe;
  localparam int LANES = 4;
  localparam int W = 2 * LANES;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] ax, bx, ay, by, z0, z1, aq, bq;
  logic [W-1:0] exp_cur, exp_saved;
  logic [W-1:0] q[$];
  int n_cmp = 0, n_err = 0, n_out = 0;
  logic acc;
  always #5 clk = ~clk;
  dom_dep_mult_pipe #(.LANES(LANES), .RAND_ON_STALL(0)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ax(ax), .bx(bx), .ay(ay), .by(by), .z0(z0), .z1(z1),
    .out_valid(out_valid), .out_ready(out_ready), .aq(aq), .bq(bq)
  );
  // GF(4) normal basis: 11 = W^0 (one), 01 = W^1, 10 = W^2; multiply by adding logs mod 3
  function automatic logic [1:0] gmul(input logic [1:0] a, input logic [1:0] b);
    int la, lb, s;
    if (a == 2'b00 || b == 2'b00) return 2'b00;
    la = (a == 2'b11) ? 0 : (a == 2'b01) ? 1 : 2;
    lb = (b == 2'b11) ? 0 : (b == 2'b01) ? 1 : 2;
    s = (la + lb) % 3;
    return (s == 0) ? 2'b11 : (s == 1) ? 2'b01 : 2'b10;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic put_lane(input int l, input logic [1:0] x, input logic [1:0] y,
                          input logic [1:0] zz0, input logic [1:0] zz1);
    logic [1:0] sa, sy;
    sa = 2'($urandom);
    sy = 2'($urandom);
    ax[2*l+:2] = sa;
    bx[2*l+:2] = sa ^ x;
    ay[2*l+:2] = sy;
    by[2*l+:2] = sy ^ y;
    z0[2*l+:2] = zz0;
    z1[2*l+:2] = zz1;
    exp_cur[2*l+:2] = gmul(x, y);
  endtask
  task automatic set_rand(input logic v, input logic r);
    for (int l = 0; l < LANES; l++)
      put_lane(l, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
    in_valid = v;
    out_ready = r;
  endtask
  // one clock: score the handshakes that happen at the coming edge, then check held outputs after it
  task automatic step();
    logic stall;
    logic [2*W:0] held;
    #1;
    stall = rst_n & out_valid & ~out_ready;
    held = {aq, bq, out_valid};
    acc = rst_n & in_valid & in_ready;
    if (!rst_n) q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_out++;
        chk("queue_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) chk("result", 32'(aq ^ bq), 32'(q.pop_front()));
      end
      if (acc) q.push_back(exp_cur);
    end
    @(posedge clk);
    #1;
    if (stall) chk("stall_hold", 32'({aq, bq, out_valid}), 32'(held));
  endtask
  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask
  initial begin
    int sent, cyc, base, p;
    bit blocked;
    exp_cur = '0;
    // reset with garbage inputs
    set_rand(1'b1, 1'b1);
    rst_n = 1'b0;
    step();
    set_rand(1'b1, 1'b0);
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_aq", 32'(aq), 32'd0);
    chk("rst_bq", 32'(bq), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    // directed lane 0: x = one, y = 10 -> 10
    set_rand(1'b1, 1'b1);
    ax[1:0] = 2'b01; bx[1:0] = 2'b10; ay[1:0] = 2'b11; by[1:0] = 2'b01;
    z0[1:0] = 2'b10; z1[1:0] = 2'b01; exp_cur[1:0] = 2'b10;
    step();
    chk("dir1_accept", 32'(acc), 32'd1);
    set_rand(1'b0, 1'b1);
    step();
    chk("dir1_valid_t2", 32'(out_valid), 32'd1);
    chk("dir1_lane0", 32'((aq ^ bq) & 8'h03), 32'h2);
    drain();
    // directed lane 0: x = 10, y = 10 -> 01
    set_rand(1'b1, 1'b1);
    put_lane(0, 2'b10, 2'b10, 2'($urandom), 2'($urandom));
    step();
    set_rand(1'b0, 1'b1);
    step();
    chk("dir2_valid_t2", 32'(out_valid), 32'd1);
    chk("dir2_lane0", 32'((aq ^ bq) & 8'h03), 32'h1);
    drain();
    // exhaustive (x,y,z0,z1) per lane with random shares and random handshakes
    sent = 0;
    cyc = 0;
    while (sent < 256 && cyc < 4000) begin
      for (int l = 0; l < LANES; l++) begin
        p = (sent + 64 * l) & 255;
        put_lane(l, 2'(p >> 6), 2'(p >> 4), 2'(p >> 2), 2'(p));
      end
      in_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 4) != 0;
      step();
      if (acc) sent++;
      cyc++;
    end
    chk("exh_all_sent", 32'(sent), 32'd256);
    drain();
    // backpressure: 6 transactions, out_ready low on cycles 3..6
    base = n_out;
    sent = 0;
    blocked = 0;
    for (int c = 1; c <= 16; c++) begin
      set_rand(sent < 6, !(c >= 3 && c <= 6));
      #1;
      if (!in_ready) blocked = 1;
      step();
      if (acc) sent++;
    end
    chk("bp_in_ready_dropped", 32'(blocked), 32'd1);
    chk("bp_sent", 32'(sent), 32'd6);
    chk("bp_results", 32'(n_out - base), 32'd6);
    drain();
    // full throughput for 20 cycles
    base = n_out;
    for (int k = 0; k < 20; k++) begin
      set_rand(1'b1, 1'b1);
      #1;
      chk("tp_in_ready", 32'(in_ready), 32'd1);
      chk("tp_out_valid", 32'(out_valid), 32'(k >= 2));
      step();
    end
    drain();
    chk("tp_results", 32'(n_out - base), 32'd20);
    // reset with both stages full
    set_rand(1'b1, 1'b0);
    step();
    set_rand(1'b1, 1'b0);
    step();
    chk("mid_full", 32'({out_valid, in_ready}), 32'b10);
    rst_n = 1'b0;
    step();
    chk("mid_out_valid", 32'(out_valid), 32'd0);
    chk("mid_aq", 32'(aq), 32'd0);
    chk("mid_bq", 32'(bq), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    set_rand(1'b1, 1'b1);
    exp_saved = exp_cur;
    step();
    set_rand(1'b0, 1'b1);
    step();
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_result", 32'(aq ^ bq), 32'(exp_saved));
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
